// File: rtl/mst_arbiter_if.sv
// Shared bus between the three command producers, the arbiter and the master FIFO write port.
// Each producer exposes its FWFT head word and empty flag and receives a pop strobe.
interface mst_arbiter_if;
  logic [17:0] req0_dout;
  logic [17:0] req1_dout;
  logic [17:0] req2_dout;
  logic        req0_empty;
  logic        req1_empty;
  logic        req2_empty;
  logic        req0_rd_en;
  logic        req1_rd_en;
  logic        req2_rd_en;
  logic [17:0] mst_din;
  logic        mst_full;
  logic        mst_wr_en;

  modport slave (
    input  req0_dout, req1_dout, req2_dout,
    input  req0_empty, req1_empty, req2_empty,
    input  mst_full,
    output req0_rd_en, req1_rd_en, req2_rd_en,
    output mst_din, mst_wr_en
  );

  modport master (
    output req0_dout, req1_dout, req2_dout,
    output req0_empty, req1_empty, req2_empty,
    output mst_full,
    input  req0_rd_en, req1_rd_en, req2_rd_en,
    input  mst_din, mst_wr_en
  );
endinterface

// File: rtl/mst_arbiter.sv
// Packet-atomic arbiter: streams whole packets from three FWFT producers into one master FIFO.
// Port 2 has strict priority; ports 0 and 1 round-robin. Stray non-SOP heads are discarded in ARB.
module mst_arbiter #(
  parameter int unsigned MAX_WORDS = 35
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         enable,
  mst_arbiter_if.slave bus,
  output logic [1:0]   grant,
  output logic         idle,
  output logic [15:0]  pkt_cnt0,
  output logic [15:0]  pkt_cnt1,
  output logic [15:0]  pkt_cnt2,
  output logic         err_frame,
  output logic         err_len,
  input  logic         err_clear
);

  typedef enum logic {ST_ARB = 1'b0, ST_XFER = 1'b1} state_e;

  localparam logic [1:0]  NO_GRANT = 2'b11;
  localparam logic [11:0] MAX_W    = 12'(MAX_WORDS);

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            last_q, last_d;
  logic [11:0]     wcnt_q, wcnt_d;
  logic [2:0][15:0] pkt_cnt_q, pkt_cnt_d;
  logic            err_frame_q, err_frame_d;
  logic            err_len_q, err_len_d;

  logic [2:0][17:0] dout_s;
  logic [2:0]      empty_s;
  logic [2:0]      cand_s;
  logic [2:0]      stray_s;
  logic [2:0]      stray_pop_s;
  logic [2:0]      rd_en_s;
  logic            any_grant_s;
  logic [1:0]      pick_s;
  logic [17:0]     g_dout_s;
  logic            g_empty_s;
  logic            beat_s;
  logic            wr_en_s;
  logic            frame_set_s;
  logic            len_set_s;

  assign dout_s      = {bus.req2_dout, bus.req1_dout, bus.req0_dout};
  assign empty_s     = {bus.req2_empty, bus.req1_empty, bus.req0_empty};
  assign cand_s      = ~empty_s & {dout_s[2][17], dout_s[1][17], dout_s[0][17]};
  assign stray_s     = ~empty_s & ~{dout_s[2][17], dout_s[1][17], dout_s[0][17]};
  assign any_grant_s = enable & (|cand_s);

  // last_q holds the port (0/1) served most recently; the other one wins a tie.
  always_comb begin
    if (cand_s[2]) begin
      pick_s = 2'd2;
    end else if (cand_s[0] && cand_s[1]) begin
      pick_s = {1'b0, ~last_q};
    end else if (cand_s[0]) begin
      pick_s = 2'd0;
    end else begin
      pick_s = 2'd1;
    end
  end

  always_comb begin
    stray_pop_s = 3'b000;
    if ((state_q == ST_ARB) && !any_grant_s) begin
      if (stray_s[0]) begin
        stray_pop_s = 3'b001;
      end else if (stray_s[1]) begin
        stray_pop_s = 3'b010;
      end else if (stray_s[2]) begin
        stray_pop_s = 3'b100;
      end else begin
        stray_pop_s = 3'b000;
      end
    end else begin
      stray_pop_s = 3'b000;
    end
  end

  always_comb begin
    case (grant_q)
      2'd0:    begin g_dout_s = dout_s[0]; g_empty_s = empty_s[0]; end
      2'd1:    begin g_dout_s = dout_s[1]; g_empty_s = empty_s[1]; end
      2'd2:    begin g_dout_s = dout_s[2]; g_empty_s = empty_s[2]; end
      default: begin g_dout_s = 18'd0;     g_empty_s = 1'b1;       end
    endcase
  end

  assign beat_s = (state_q == ST_XFER) & ~g_empty_s & ~bus.mst_full;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= ST_ARB;
      grant_q     <= NO_GRANT;
      last_q      <= 1'b1;
      wcnt_q      <= 12'd0;
      pkt_cnt_q   <= '0;
      err_frame_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      wcnt_q      <= wcnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_frame_q <= err_frame_d;
      err_len_q   <= err_len_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    wcnt_d      = wcnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    frame_set_s = 1'b0;
    len_set_s   = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (any_grant_s) begin
          grant_d = pick_s;
          wcnt_d  = 12'd0;
          state_d = ST_XFER;
        end else begin
          frame_set_s = |stray_pop_s;
        end
      end
      ST_XFER: begin
        if (grant_q == NO_GRANT) begin
          state_d = ST_ARB;
        end else if (beat_s) begin
          if (wcnt_q != 12'hFFF) begin
            wcnt_d = wcnt_q + 12'd1;
          end else begin
            wcnt_d = wcnt_q;
          end
          frame_set_s = (wcnt_q != 12'd0) & g_dout_s[17];
          if (g_dout_s[16]) begin
            case (grant_q)
              2'd0:    pkt_cnt_d[0] = pkt_cnt_q[0] + 16'd1;
              2'd1:    pkt_cnt_d[1] = pkt_cnt_q[1] + 16'd1;
              2'd2:    pkt_cnt_d[2] = pkt_cnt_q[2] + 16'd1;
              default: pkt_cnt_d    = pkt_cnt_q;
            endcase
            if (grant_q != 2'd2) begin
              last_d = grant_q[0];
            end else begin
              last_d = last_q;
            end
            grant_d = NO_GRANT;
            state_d = ST_ARB;
          end else begin
            // Equality with a saturating counter fires at most once per packet.
            len_set_s = ((wcnt_q + 12'd1) == MAX_W);
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      default: begin
        state_d = ST_ARB;
        grant_d = NO_GRANT;
      end
    endcase
    err_frame_d = frame_set_s | (err_frame_q & ~err_clear);
    err_len_d   = len_set_s | (err_len_q & ~err_clear);
  end

  always_comb begin
    rd_en_s = 3'b000;
    wr_en_s = 1'b0;
    if (!sys_rst_n) begin
      rd_en_s = 3'b000;
      wr_en_s = 1'b0;
    end else if (state_q == ST_XFER) begin
      wr_en_s = beat_s;
      case (grant_q)
        2'd0:    rd_en_s = {2'b00, beat_s};
        2'd1:    rd_en_s = {1'b0, beat_s, 1'b0};
        2'd2:    rd_en_s = {beat_s, 2'b00};
        default: rd_en_s = 3'b000;
      endcase
    end else begin
      rd_en_s = stray_pop_s;
    end
  end

  assign bus.req0_rd_en = rd_en_s[0];
  assign bus.req1_rd_en = rd_en_s[1];
  assign bus.req2_rd_en = rd_en_s[2];
  assign bus.mst_din    = g_dout_s;
  assign bus.mst_wr_en  = wr_en_s;

  assign grant     = grant_q;
  assign idle      = (state_q == ST_ARB);
  assign pkt_cnt0  = pkt_cnt_q[0];
  assign pkt_cnt1  = pkt_cnt_q[1];
  assign pkt_cnt2  = pkt_cnt_q[2];
  assign err_frame = err_frame_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_mst_arbiter.sv
// Bench for mst_arbiter: producer FIFO models, an ordered scoreboard of expected master writes,
// a table of single-cycle arbitration vectors and hand-written multi-cycle sequences.
module tb_mst_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, enable, err_clear;
  logic [1:0]  grant;
  logic        idle, err_frame, err_len;
  logic [15:0] pc0, pc1, pc2;

  always #5 clk = ~clk;

  mst_arbiter_if bus();

  mst_arbiter #(.MAX_WORDS(35)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .enable(enable), .bus(bus),
    .grant(grant), .idle(idle), .pkt_cnt0(pc0), .pkt_cnt1(pc1), .pkt_cnt2(pc2),
    .err_frame(err_frame), .err_len(err_len), .err_clear(err_clear)
  );

  typedef struct packed { logic [17:0] word; logic [1:0] port; } exp_t;
  typedef struct { logic en; logic [1:0] h0; logic [1:0] h1; logic [1:0] h2;
                   logic [2:0] exp_rd; logic [1:0] exp_grant; } vec_t;

  logic [17:0] pq0[$], pq1[$], pq2[$];
  exp_t        exp_q[$];
  logic [2:0]  hold_empty = 3'b000;
  logic [2:0]  pop_pend = 3'b000;
  int          total = 0, bad = 0, cyc_n = 0, wr_cnt = 0, last_wr_cyc = 0;
  logic        prev_last = 1'b0, gap_chk = 1'b0;
  int          exp_cnt[3];
  vec_t        vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic refresh();
    bus.req0_empty = (pq0.size() == 0) | hold_empty[0];
    bus.req1_empty = (pq1.size() == 0) | hold_empty[1];
    bus.req2_empty = (pq2.size() == 0) | hold_empty[2];
    bus.req0_dout  = (pq0.size() != 0) ? pq0[0] : 18'd0;
    bus.req1_dout  = (pq1.size() != 0) ? pq1[0] : 18'd0;
    bus.req2_dout  = (pq2.size() != 0) ? pq2[0] : 18'd0;
  endtask

  task automatic pq_push(input int p, input logic [17:0] w);
    case (p)
      0: pq0.push_back(w);
      1: pq1.push_back(w);
      default: pq2.push_back(w);
    endcase
  endtask

  // len words, word 0 and word sop_at carry [17]; only the first nexp words are expected on the master side
  task automatic push_pkt(input int p, input int len, input int tag, input int nexp, input int sop_at);
    logic [17:0] w;
    exp_t e;
    for (int k = 0; k < len; k++) begin
      w = {(k == 0) || (k == sop_at), (k == len - 1), 16'(tag * 256 + k)};
      pq_push(p, w);
      if (k < nexp) begin
        e.word = w;
        e.port = 2'(p);
        exp_q.push_back(e);
      end
    end
    refresh();
  endtask

  task automatic half1();
    exp_t e;
    @(negedge clk);
    cyc_n++;
    pop_pend = {bus.req2_rd_en, bus.req1_rd_en, bus.req0_rd_en};
    if (!rst_n) check("rst_strobes", {28'd0, pop_pend, bus.mst_wr_en}, 32'd0);
    if (bus.mst_wr_en) begin
      wr_cnt++;
      check("no_wr_when_full", {31'd0, bus.mst_full}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got %0h want no write", bus.mst_din);
      end else begin
        e = exp_q.pop_front();
        check("mst_din", {14'd0, bus.mst_din}, {14'd0, e.word});
        check("wr_grant", {30'd0, grant}, {30'd0, e.port});
        if (gap_chk && e.word[17] && prev_last) check("gap", cyc_n - last_wr_cyc, 2);
        prev_last   = e.word[16];
        last_wr_cyc = cyc_n;
        if (e.word[16]) exp_cnt[e.port]++;
      end
    end
  endtask

  task automatic half2();
    logic [17:0] dummy;
    @(posedge clk);
    #1;
    if (pop_pend[0] && pq0.size() != 0) dummy = pq0.pop_front();
    if (pop_pend[1] && pq1.size() != 0) dummy = pq1.pop_front();
    if (pop_pend[2] && pq2.size() != 0) dummy = pq2.pop_front();
    refresh();
  endtask

  task automatic cyc();
    half1();
    half2();
  endtask

  task automatic run_drain(input int maxc, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !idle) && n < maxc) begin
      cyc();
      n++;
    end
    check(name, {31'd0, n < maxc}, 32'd1);
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    repeat (ncyc) cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_pc0"}, {16'd0, pc0}, exp_cnt[0]);
    check({tag, "_pc1"}, {16'd0, pc1}, exp_cnt[1]);
    check({tag, "_pc2"}, {16'd0, pc2}, exp_cnt[2]);
  endtask

  initial begin
    int w0, n;
    logic [1:0] code;
    // head codes: 0 = empty, 1 = single-word packet, 2 = stray word
    vt[0] = '{1'b1, 2'd1, 2'd1, 2'd0, 3'b000, 2'd0};
    vt[1] = '{1'b1, 2'd1, 2'd1, 2'd0, 3'b000, 2'd1};
    vt[2] = '{1'b1, 2'd1, 2'd1, 2'd1, 3'b000, 2'd2};
    vt[3] = '{1'b1, 2'd1, 2'd1, 2'd0, 3'b000, 2'd0};
    vt[4] = '{1'b0, 2'd1, 2'd1, 2'd1, 3'b000, 2'd3};
    vt[5] = '{1'b0, 2'd2, 2'd1, 2'd2, 3'b001, 2'd3};
    vt[6] = '{1'b1, 2'd2, 2'd1, 2'd0, 3'b000, 2'd1};
    vt[7] = '{1'b1, 2'd0, 2'd2, 2'd2, 3'b010, 2'd3};
    vt[8] = '{1'b1, 2'd0, 2'd0, 2'd1, 3'b000, 2'd2};
    vt[9] = '{1'b1, 2'd1, 2'd0, 2'd2, 3'b000, 2'd0};

    rst_n = 1'b0; enable = 1'b1; err_clear = 1'b0; bus.mst_full = 1'b0;
    refresh();
    do_reset(2);
    check("rst_grant", {30'd0, grant}, 32'd3);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_errs", {30'd0, err_frame, err_len}, 32'd0);
    check_counts("rst");

    // arbitration vector table, applied from ARB with fresh heads each row
    for (int i = 0; i < 10; i++) begin
      enable = vt[i].en;
      pq0.delete(); pq1.delete(); pq2.delete();
      for (int p = 0; p < 3; p++) begin
        code = (p == 0) ? vt[i].h0 : (p == 1) ? vt[i].h1 : vt[i].h2;
        if (code == 2'd1) begin
          pq_push(p, {2'b11, 16'(16'hA000 + i * 16 + p)});
          if (p == int'(vt[i].exp_grant)) exp_q.push_back('{{2'b11, 16'(16'hA000 + i * 16 + p)}, 2'(p)});
        end else if (code == 2'd2) begin
          pq_push(p, 18'h00123);
        end
      end
      refresh();
      half1();
      check($sformatf("vec%0d_rd_en", i), {29'd0, pop_pend}, {29'd0, vt[i].exp_rd});
      check($sformatf("vec%0d_idle", i), {31'd0, idle}, 32'd1);
      half2();
      check($sformatf("vec%0d_grant", i), {30'd0, grant}, {30'd0, vt[i].exp_grant});
      if (vt[i].exp_grant != 2'd0) pq0.delete();
      if (vt[i].exp_grant != 2'd1) pq1.delete();
      if (vt[i].exp_grant != 2'd2) pq2.delete();
      refresh();
      run_drain(8, $sformatf("vec%0d_done", i));
    end
    check("vec_err_frame", {31'd0, err_frame}, 32'd1);
    check_counts("vec");
    enable = 1'b1;

    // 35-word packet: grant one cycle after request, 35 back-to-back writes
    push_pkt(0, 35, 8'h10, 35, -1);
    half1();
    check("lat_no_write", {31'd0, bus.mst_wr_en}, 32'd0);
    half2();
    check("lat_grant", {30'd0, grant}, 32'd0);
    w0 = wr_cnt;
    repeat (35) cyc();
    check("long_consecutive", wr_cnt - w0, 35);
    check("long_idle", {31'd0, idle}, 32'd1);
    check("long_err_len", {31'd0, err_len}, 32'd0);
    check_counts("long");

    // round-robin from reset with contiguous packets and one gap cycle
    do_reset(1);
    check("rst2_err_frame", {31'd0, err_frame}, 32'd0);
    check_counts("rst2");
    gap_chk = 1'b1; prev_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_pkt(0, 5, 8'h20 + k, 5, -1);
      push_pkt(1, 5, 8'h30 + k, 5, -1);
    end
    run_drain(200, "rr_drain");
    gap_chk = 1'b0;
    check_counts("rr");

    // port 2 arrives mid-packet: port 0 finishes, then port 2 ahead of port 1
    push_pkt(0, 10, 8'h40, 10, -1);
    repeat (4) cyc();
    push_pkt(1, 4, 8'h41, 0, -1);
    push_pkt(2, 3, 8'h42, 0, -1);
    for (int k = 0; k < 3; k++) exp_q.push_back('{{(k == 0), (k == 2), 16'(16'h4200 + k)}, 2'd2});
    for (int k = 0; k < 4; k++) exp_q.push_back('{{(k == 0), (k == 3), 16'(16'h4100 + k)}, 2'd1});
    run_drain(100, "prio_drain");
    check_counts("prio");

    // stalls: mst_full every 3rd cycle, producer empty pulses mid-packet
    push_pkt(0, 8, 8'h50, 8, -1);
    push_pkt(1, 6, 8'h51, 6, -1);
    n = 0;
    while ((exp_q.size() != 0 || !idle) && n < 300) begin
      bus.mst_full = ((n % 3) == 2);
      hold_empty = {1'b0, n == 17, (n == 5) || (n == 6)};
      refresh();
      cyc();
      n++;
    end
    bus.mst_full = 1'b0; hold_empty = 3'b000; refresh();
    check("stall_drain", {31'd0, n < 300}, 32'd1);
    check_counts("stall");

    // stray word, then an over-long packet with an interior SOP word
    check("pre_err", {30'd0, err_frame, err_len}, 32'd0);
    pq_push(1, 18'h00123);
    push_pkt(1, 40, 8'h60, 40, 10);
    run_drain(120, "err_drain");
    check("err_frame_set", {31'd0, err_frame}, 32'd1);
    check("err_len_set", {31'd0, err_len}, 32'd1);
    err_clear = 1'b1;
    cyc();
    err_clear = 1'b0;
    check("err_cleared", {30'd0, err_frame, err_len}, 32'd0);

    // enable drop mid-packet, then reset in the middle of a later packet
    push_pkt(0, 8, 8'h70, 8, -1);
    n = 0;
    while (grant != 2'd0 && n < 20) begin cyc(); n++; end
    check("en_grant0", {30'd0, grant}, 32'd0);
    repeat (3) cyc();
    enable = 1'b0;
    push_pkt(1, 6, 8'h71, 3, -1);
    repeat (10) cyc();
    check("en_hold_grant", {30'd0, grant}, 32'd3);
    check("en_hold_idle", {31'd0, idle}, 32'd1);
    check("en_hold_q1", pq1.size(), 6);
    check("en_hold_sb", exp_q.size(), 3);
    enable = 1'b1;
    n = 0;
    while (grant != 2'd1 && n < 20) begin cyc(); n++; end
    check("en_grant1", {30'd0, grant}, 32'd1);
    repeat (3) cyc();
    do_reset(1);
    check("rst3_grant", {30'd0, grant}, 32'd3);
    check("rst3_idle", {31'd0, idle}, 32'd1);
    check_counts("rst3");
    w0 = wr_cnt;
    n = 0;
    while (pq1.size() != 0 && n < 20) begin cyc(); n++; end
    check("stray_flush_q1", pq1.size(), 0);
    check("stray_no_write", wr_cnt - w0, 0);
    check("stray_err_frame", {31'd0, err_frame}, 32'd1);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
